sfi_dce_slv_slice: RTL
======================

Name: sfi_dce_slv_slice

Overview:
- Registered request/response slice that sits directly upstream of the DCE's SFI slave port. It sits between the fabric/initiator and the DCE's sfi_slv_* pins.
- Decouples timing with a 2-entry request FIFO and a 2-entry response FIFO.
- Limits the number of outstanding SFI packets presented to the DCE and flags protocol underflow.
- Payloads are carried as packed structs. Per-cycle press/hurry sideband is retimed by one register stage.

Parameters:
- MAX_OUT, 4, maximum outstanding request packets (first beat issued, last response beat not yet delivered); legal 1..15.
- REQ_DEPTH, 2, request FIFO entries; fixed at 2, assertion if changed.
- RSP_DEPTH, 2, response FIFO entries; fixed at 2, assertion if changed.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_req_vld  in  1  upstream request valid
- s_req_rdy  out  1  upstream request ready
- s_req_pld  in  172  sfi_req_pld_t: addr40, be8, burst1, data64, last1, length6, opc1, protbits8, security3, sfipriv20, sfislvid3, transid8, urgency3
- s_req_press  in  3  upstream press sideband
- s_req_hurry  in  3  upstream hurry sideband
- s_rsp_vld  out  1  upstream response valid
- s_rsp_rdy  in  1  upstream response ready
- s_rsp_pld  out  105  sfi_rsp_pld_t: data64, errcode3, last1, protbits8, sfipriv20, status1, transid8
- m_req_vld  out  1  request valid to DCE sfi_slv_req_vld
- m_req_rdy  in  1  DCE sfi_slv_req_rdy
- m_req_pld  out  172  request payload to DCE
- m_req_press  out  3  registered press to DCE
- m_req_hurry  out  3  registered hurry to DCE
- m_rsp_vld  in  1  DCE sfi_slv_rsp_vld
- m_rsp_rdy  out  1  DCE sfi_slv_rsp_rdy
- m_rsp_pld  in  105  DCE response payload
- outstanding  out  4  current outstanding packet count
- err_underflow  out  1  sticky: last response beat seen while outstanding==0

Behaviour:
- Reset (async assert, sync deassert handled upstream). All FIFOs empty; in_pkt=0; outstanding=0; err_underflow=0; press/hurry regs=0. Resulting outputs: s_req_rdy=1, m_rsp_rdy=1, m_req_vld=0, s_rsp_vld=0.
- Handshake: a beat transfers when vld&rdy in the same cycle. Valid never depends combinationally on rdy of the same interface. Payload is held stable while vld=1 and rdy=0.
- Request FIFO:
  - s_req_rdy = !full, driven from registers only.
  - Write on s_req_vld&s_req_rdy; read on m_req_vld&m_req_rdy.
  - Simultaneous read and write when full is not allowed: rdy is already 0. Simultaneous read and write at count 1 leaves count 1.
  - Minimum latency s_req to m_req is 1 cycle; no combinational bypass.
- Issue gate:
  - m_req_vld = !req_empty & (in_pkt | outstanding<MAX_OUT).
  - in_pkt sets on an issued beat with last=0 and clears on an issued beat with last=1.
  - Once a packet starts, its remaining beats are never gated.
- Outstanding counter:
  - +1 on an issued first beat (in_pkt==0).
  - -1 on a delivered last response beat (s_rsp_vld&s_rsp_rdy&last).
  - Increment and decrement in the same cycle leave it unchanged.
  - Saturates at 0: a decrement at 0 sets err_underflow, which stays set until reset, and the count stays 0.
  - Never exceeds MAX_OUT; assertion.
- Response FIFO: mirrors the request FIFO.
  - m_rsp_rdy = !rsp_full.
  - s_rsp_vld = !rsp_empty; s_rsp_pld comes from the head entry.
  - 1-cycle minimum latency.
- Sideband: m_req_press and m_req_hurry equal s_req_press and s_req_hurry delayed by 1 cycle, unconditionally and independent of any handshake.
- Reset mid-packet: all state is discarded immediately, including in_pkt and the counter. No beats are replayed.
- Order: strict FIFO order on both channels. No reordering or transid interpretation.

Decomposition:
- Package sfi_dce_pkg holds:
  - sfi_req_pld_t, sfi_rsp_pld_t
  - SFI_ADDR_W=40, SFI_DATA_W=64, SFI_TRANSID_W=8, SFI_PRIV_W=20
  - SFI_REQ_PLD_W=172, SFI_RSP_PLD_W=105
- One sub-module, sfi_fifo2: a parameterised-width 2-entry registered FIFO with vld/rdy on both sides. It is instantiated twice (request and response).
- Gate, counter and sideband registers live in the top module.

Test Plan:
- Single 1-beat request with m_req_rdy=1:
  - Beat appears on m_req 1 cycle after acceptance and outstanding goes to 1.
  - A response with last=1 appears on s_rsp 1 cycle later and outstanding returns to 0.
- Backpressure: hold m_req_rdy=0 and drive 3 back-to-back beats.
  - s_req_rdy drops to 0 after 2 accepts.
  - Releasing rdy drains the beats in order with payload unchanged (check transid 0x11, 0x12, 0x13).
- Limit, MAX_OUT=4: issue 5 single-beat packets with no responses.
  - The 5th is held with m_req_vld=0 and outstanding=4.
  - One last response delivered lets the 5th issue the next cycle.
- Multi-beat packet (length 4, last on beat 4) started at outstanding=3:
  - All 4 beats issue without a gap and outstanding=4.
  - The same-cycle issue of a first beat and delivery of a last response leaves outstanding unchanged.
- A response with last=1 while outstanding=0 sets err_underflow=1. It stays 1 until rst_n pulses low, and outstanding stays 0.
- Assert rst_n=0 mid-packet with both FIFOs holding 2 entries.
  - Outputs go immediately to their reset values: vld=0, rdy=1, outstanding=0.
  - After release, a new 1-beat request passes with 1-cycle latency.

Source files
------------

// File: rtl/sfi_dce_pkg.sv
// Shared SFI payload types and widths for the DCE slave-port slice.
package sfi_dce_pkg;

  localparam int SFI_ADDR_W    = 40;
  localparam int SFI_DATA_W    = 64;
  localparam int SFI_TRANSID_W = 8;
  localparam int SFI_PRIV_W    = 20;
  localparam int SFI_REQ_PLD_W = 172;
  localparam int SFI_RSP_PLD_W = 105;

  // Named fields sum to 166 bits; rsvd pads the struct to the 172-bit pin width.
  typedef struct packed {
    logic [SFI_ADDR_W-1:0]    addr;
    logic [7:0]               be;
    logic                     burst;
    logic [SFI_DATA_W-1:0]    data;
    logic                     last;
    logic [5:0]               length;
    logic                     opc;
    logic [7:0]               protbits;
    logic [2:0]               security;
    logic [SFI_PRIV_W-1:0]    sfipriv;
    logic [2:0]               sfislvid;
    logic [SFI_TRANSID_W-1:0] transid;
    logic [2:0]               urgency;
    logic [5:0]               rsvd;
  } sfi_req_pld_t;

  typedef struct packed {
    logic [SFI_DATA_W-1:0]    data;
    logic [2:0]               errcode;
    logic                     last;
    logic [7:0]               protbits;
    logic [SFI_PRIV_W-1:0]    sfipriv;
    logic                     status;
    logic [SFI_TRANSID_W-1:0] transid;
  } sfi_rsp_pld_t;

endpackage

// File: rtl/sfi_fifo2.sv
// Two-entry registered FIFO; both ready and valid come straight from the occupancy count.
module sfi_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         wr;
  logic         rd;

  assign in_rdy   = (count != 2'd2);
  assign out_vld  = (count != 2'd0);
  assign out_data = mem[rd_ptr];
  assign wr       = in_vld & in_rdy;
  assign rd       = out_vld & out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr) wr_ptr <= ~wr_ptr;
      if (rd) rd_ptr <= ~rd_ptr;
      case ({wr, rd})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset: it is only observable while count marks it valid.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/sfi_dce_slv_slice.sv
// Registered request/response slice in front of the DCE SFI slave port with an
// outstanding-packet issue gate, sticky underflow flag and retimed press/hurry.
module sfi_dce_slv_slice
  import sfi_dce_pkg::*;
#(
  parameter int MAX_OUT   = 4,
  parameter int REQ_DEPTH = 2,
  parameter int RSP_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_req_vld,
  output logic         s_req_rdy,
  input  sfi_req_pld_t s_req_pld,
  input  logic [2:0]   s_req_press,
  input  logic [2:0]   s_req_hurry,
  output logic         s_rsp_vld,
  input  logic         s_rsp_rdy,
  output sfi_rsp_pld_t s_rsp_pld,
  output logic         m_req_vld,
  input  logic         m_req_rdy,
  output sfi_req_pld_t m_req_pld,
  output logic [2:0]   m_req_press,
  output logic [2:0]   m_req_hurry,
  input  logic         m_rsp_vld,
  output logic         m_rsp_rdy,
  input  sfi_rsp_pld_t m_rsp_pld,
  output logic [3:0]   outstanding,
  output logic         err_underflow
);

  localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

  if (REQ_DEPTH != 2) begin : g_bad_req_depth
    $error("sfi_dce_slv_slice: REQ_DEPTH must be 2");
  end
  if (RSP_DEPTH != 2) begin : g_bad_rsp_depth
    $error("sfi_dce_slv_slice: RSP_DEPTH must be 2");
  end
  if (MAX_OUT < 1 || MAX_OUT > 15) begin : g_bad_max_out
    $error("sfi_dce_slv_slice: MAX_OUT must be 1..15");
  end

  // Valid/ready: a beat moves when vld & rdy are both high at a rising edge; vld
  // never looks at same-side rdy, and payload holds while vld & !rdy.
  logic req_head_vld;
  logic req_pop;
  logic issue_ok;
  logic issue;
  logic inc;
  logic dec;
  logic in_pkt;

  sfi_fifo2 #(.W(SFI_REQ_PLD_W)) u_req_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (s_req_vld),
    .in_rdy   (s_req_rdy),
    .in_data  (s_req_pld),
    .out_vld  (req_head_vld),
    .out_rdy  (req_pop),
    .out_data (m_req_pld)
  );

  sfi_fifo2 #(.W(SFI_RSP_PLD_W)) u_rsp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (m_rsp_vld),
    .in_rdy   (m_rsp_rdy),
    .in_data  (m_rsp_pld),
    .out_vld  (s_rsp_vld),
    .out_rdy  (s_rsp_rdy),
    .out_data (s_rsp_pld)
  );

  // A packet already in flight is never stalled by the limit.
  assign issue_ok  = in_pkt | (outstanding < MAX_OUT_C);
  assign m_req_vld = req_head_vld & issue_ok;
  assign req_pop   = m_req_rdy & issue_ok;
  assign issue     = m_req_vld & m_req_rdy;
  assign inc       = issue & ~in_pkt;
  assign dec       = s_rsp_vld & s_rsp_rdy & s_rsp_pld.last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_pkt        <= 1'b0;
      outstanding   <= 4'd0;
      err_underflow <= 1'b0;
    end else begin
      if (issue) in_pkt <= ~m_req_pld.last;
      if (dec && outstanding == 4'd0) err_underflow <= 1'b1;
      if (inc && !dec) begin
        outstanding <= outstanding + 4'd1;
      end else if (dec && !inc && outstanding != 4'd0) begin
        outstanding <= outstanding - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req_press <= 3'd0;
      m_req_hurry <= 3'd0;
    end else begin
      m_req_press <= s_req_press;
      m_req_hurry <= s_req_hurry;
    end
  end

  a_out_le_max: assert property (@(posedge clk) disable iff (!rst_n) outstanding <= MAX_OUT_C)
    else $error("outstanding exceeded MAX_OUT");

endmodule
